// File: rtl/timer_pkg.sv
// Shared widths and clock-select encodings for the timer prescaler.
package timer_pkg;

    localparam int CKS_W = 2;
    localparam int DIV_W = 1 << CKS_W;

    typedef enum logic [CKS_W-1:0] {
        CKS_DIV2  = 2'd0,
        CKS_DIV4  = 2'd1,
        CKS_DIV8  = 2'd2,
        CKS_DIV16 = 2'd3
    } cks_e;

endpackage

// File: rtl/timer_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for an asynchronous input.
// Only built with TIMER_EXT_CLK_EN defined; the prescaler has no external clock otherwise.
`ifdef TIMER_EXT_CLK_EN
module timer_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // sh[0], sh[1] synchronize; sh[2] is the previous synchronized value
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], din};
        end
    end

    assign rise = sh[1] & ~sh[2];

endmodule
`endif

// File: rtl/timer_clk_ena_gen.sv
// Timer prescaler: divides clk by 2/4/8/16 and emits a one-cycle clk_ena count strobe.
// Optional external count clock selected with macro TIMER_EXT_CLK_EN.
module timer_clk_ena_gen
    import timer_pkg::*;
#(
    parameter int CKS_W = timer_pkg::CKS_W,
    parameter int DIV_W = 1 << CKS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [CKS_W-1:0] cks,
    input  logic             presc_clr,
`ifdef TIMER_EXT_CLK_EN
    input  logic             ext_clk,
    input  logic             ext_sel,
`endif
    output logic             clk_ena
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] mask;
    logic [CKS_W-1:0] cks_q;
    logic             restart;
    logic             div_hit;
    logic             ena_nxt;

    // Mask covers div_cnt[k:0]; the strobe fires when those bits are all ones
    always_comb begin
        mask = '0;
        for (int i = 0; i < DIV_W; i++) begin
            mask[i] = (i <= int'(cks));
        end
    end

    assign div_hit = ((div_cnt & mask) == mask);

`ifdef TIMER_EXT_CLK_EN
    logic sel_q;
    logic ext_pulse;

    timer_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ext_clk),
        .rise  (ext_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
        end else begin
            sel_q <= ext_sel;
        end
    end

    assign restart = presc_clr | (cks != cks_q) | (ext_sel != sel_q);
`else
    assign restart = presc_clr | (cks != cks_q);
`endif

    always_comb begin
        div_nxt = div_cnt + DIV_W'(1);
        ena_nxt = div_hit;
        if (!run) begin
            div_nxt = '0;
            ena_nxt = 1'b0;
        end else if (restart) begin
            div_nxt = '0;
            ena_nxt = 1'b0;
        end
`ifdef TIMER_EXT_CLK_EN
        // Divider keeps running in external mode; only its strobe is replaced
        if (run && ext_sel) begin
            ena_nxt = ext_pulse;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            cks_q   <= CKS_W'(CKS_DIV2);
            clk_ena <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            cks_q   <= cks;
            clk_ena <= ena_nxt;
        end
    end

endmodule

// File: tb/tb_timer_clk_ena_gen.sv
// Directed bench for the timer prescaler: reset, each divide ratio, restarts and run gating.
module tb_timer_clk_ena_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [1:0] cks = 2'd0;
    logic       presc_clr = 1'b0;
    logic       clk_ena;
`ifdef TIMER_EXT_CLK_EN
    logic       ext_clk = 1'b0;
    logic       ext_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_clk_ena_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .cks       (cks),
        .presc_clr (presc_clr),
`ifdef TIMER_EXT_CLK_EN
        .ext_clk   (ext_clk),
        .ext_sel   (ext_sel),
`endif
        .clk_ena   (clk_ena)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        cks = 2'd0;
        presc_clr = 1'b0;
        repeat (5) tick();
        total++;
        if (clk_ena !== 1'b0 || dut.div_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_state ena=%b cnt=%0d want ena=0 cnt=0", clk_ena, dut.div_cnt);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            total++;
            if (clk_ena !== 1'b0 || dut.div_cnt !== 4'd0) begin
                bad++;
                $display("FAIL run_low n=%0d ena=%b cnt=%0d want ena=0 cnt=0", n, clk_ena, dut.div_cnt);
            end
        end
    endtask

    task automatic test_div2();
        int strobes = 0;
        logic exp;
        run = 1'b1;
        for (int n = 1; n <= 492; n++) begin
            tick();
            exp = (n % 2 == 0);
            if (clk_ena === 1'b1) strobes++;
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL div2 n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        total++;
        if (strobes != 246) begin
            bad++;
            $display("FAIL div2_count got=%0d want=246", strobes);
        end
    endtask

    task automatic test_cks_switch();
        logic exp;
        run = 1'b0;
        cks = 2'd3;
        tick();
        run = 1'b1;
        for (int n = 1; n <= 41; n++) begin
            tick();
            exp = (n == 16) || (n == 32);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL div16 n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        total++;
        if (dut.div_cnt !== 4'd9) begin
            bad++;
            $display("FAIL div16_phase got=%0d want=9", dut.div_cnt);
        end
        cks = 2'd1;
        for (int n = 1; n <= 13; n++) begin
            tick();
            exp = (n == 5) || (n == 9) || (n == 13);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL cks_switch n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
    endtask

    task automatic test_presc_clr();
        logic exp;
        cks = 2'd2;
        for (int n = 1; n <= 22; n++) begin
            tick();
            exp = (n == 9) || (n == 17);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL div8 n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        total++;
        if (dut.div_cnt !== 4'd5) begin
            bad++;
            $display("FAIL div8_phase got=%0d want=5", dut.div_cnt);
        end
        presc_clr = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            tick();
            presc_clr = 1'b0;
            exp = (n == 9) || (n == 17) || (n == 25);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL presc_clr n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        // clk_ena is high now; a clear in this cycle restarts the full period
        presc_clr = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            tick();
            presc_clr = 1'b0;
            exp = (n == 9);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL clr_on_strobe n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
    endtask

    task automatic test_run_drop();
        logic exp;
        for (int n = 1; n <= 14; n++) begin
            tick();
            exp = (n == 8);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL pre_drop n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        total++;
        if (dut.div_cnt !== 4'd6) begin
            bad++;
            $display("FAIL drop_phase got=%0d want=6", dut.div_cnt);
        end
        run = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++;
            if (clk_ena !== 1'b0) begin
                bad++;
                $display("FAIL run_dropped n=%0d got=%b want=0", n, clk_ena);
            end
        end
        run = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            tick();
            exp = (n == 8) || (n == 16);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL run_resume n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic exp;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = (n == 8);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL pre_reset n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (clk_ena !== 1'b0 || dut.div_cnt !== 4'd0) begin
            bad++;
            $display("FAIL async_reset ena=%b cnt=%0d want ena=0 cnt=0", clk_ena, dut.div_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            tick();
            exp = (n == 9) || (n == 17);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL post_reset n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
    endtask

`ifdef TIMER_EXT_CLK_EN
    task automatic test_ext_clk();
        logic exp;
        cks = 2'd0;
        ext_sel = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            ext_clk = ((n % 10) >= 1) && ((n % 10) <= 5);
            tick();
            exp = (n % 10 == 3);
            total++;
            if (clk_ena !== exp) begin
                bad++;
                $display("FAIL ext_clk n=%0d got=%b want=%b", n, clk_ena, exp);
            end
        end
        ext_sel = 1'b0;
        ext_clk = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_div2();
        test_cks_switch();
        test_presc_clr();
        test_run_drop();
        test_reset_mid();
`ifdef TIMER_EXT_CLK_EN
        test_ext_clk();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
